// File: rtl/ifu_pc_sequencer_pkg.sv
// Purpose: shared constants, cause codes and state encoding for the IFU PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pc_sequencer_pkg;

    // Default memory map for the instruction fetch unit.
    localparam logic [31:0] PC_RESET_DEF    = 32'h0000_3000;
    localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_TOP_DEF      = 32'h0000_4FFC;

    // Cause code recorded for an instruction-fetch address error.
    localparam logic [4:0]  EXC_ADEL        = 5'd4;

    // Sequencer mode. The encoding is visible to software debug, keep it fixed.
    typedef enum logic [1:0] {
        ST_USER   = 2'b00,
        ST_KERNEL = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

    // Word-aligned and inside [lo, hi] inclusive.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/ifu_addr_chk.sv
// Purpose: flags an illegal instruction-fetch address (misaligned or outside IM window).
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
//
// Ports:
//   pc    in  32  fetch address to check
//   fault out  1  pc is misaligned, below lo_addr or above hi_addr
module ifu_addr_chk
    import ifu_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] LO_ADDR = PC_RESET_DEF,
    parameter logic [31:0] HI_ADDR = IM_TOP_DEF
) (
    input  logic [31:0] pc,
    output logic        fault
);

    always_comb begin
        fault = !addr_legal(pc, LO_ADDR, HI_ADDR);
    end

endmodule

// File: rtl/ifu_pc_sequencer.sv
// Purpose: fetch PC sequencer with branch redirect, exception entry/return and double-fault halt.
// Latency: every redirect (branch, exception, eret) becomes the new pc exactly one cycle later.
// Backpressure: stall holds pc and mode and drops a pending branch; exceptions still enter.
//
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   stall                      hold pc/mode (exception entry still allowed)
//   br_valid, br_target        branch/jump redirect
//   exc_req, exc_code          external exception/interrupt request and cause
//   eret, epc_in               return from handler and its target
//   pc, fetch_valid            fetch address and its legality/activity
//   exl, cause, epc_out        handler-mode flag, latched cause, exception pc
//   bad_vaddr, halted          faulting fetch address, double-fault halt flag
module ifu_pc_sequencer
    import ifu_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PC_RESET_DEF,
    parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEF,
    parameter logic [31:0] IM_TOP      = IM_TOP_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [31:0] epc_in,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        exl,
    output logic [4:0]  cause,
    output logic [31:0] epc_out,
    output logic [31:0] bad_vaddr,
    output logic        halted
);

    state_t      state;
    logic        fault;
    logic [31:0] pc_inc;

    ifu_addr_chk #(
        .LO_ADDR (PC_RESET),
        .HI_ADDR (IM_TOP)
    ) u_addr_chk (
        .pc    (pc),
        .fault (fault)
    );

    // Wraps modulo 2^32; a wrapped or over-the-top pc is caught by the checker
    // on the cycle it is presented.
    always_comb begin
        pc_inc = pc + 32'd4;
    end

    // The fault is a function of the current pc, so an illegal target is
    // fetched-invalid on its own cycle and acted on at the following edge.
    always_comb begin
        fetch_valid = (state != ST_HALT) && !fault;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_USER;
            pc        <= PC_RESET;
            exl       <= 1'b0;
            halted    <= 1'b0;
            cause     <= 5'd0;
            epc_out   <= 32'd0;
            bad_vaddr <= 32'd0;
        end else begin
            case (state)
                ST_USER: begin
                    // Entry ignores stall: the faulting/interrupted fetch must not retire.
                    if (fault || exc_req) begin
                        state   <= ST_KERNEL;
                        exl     <= 1'b1;
                        pc      <= HANDLER_VEC;
                        epc_out <= pc;
                        if (fault) begin
                            cause     <= EXC_ADEL;
                            bad_vaddr <= pc;
                        end else begin
                            cause <= exc_code;
                        end
                    end else if (stall) begin
                        pc <= pc;
                    end else if (br_valid) begin
                        pc <= br_target;
                    end else begin
                        pc <= pc_inc;
                    end
                    // eret has no meaning outside the handler and falls through.
                end

                ST_KERNEL: begin
                    if (fault) begin
                        // Faulting inside the handler cannot be recovered; freeze
                        // the pc so the offending address stays observable.
                        state     <= ST_HALT;
                        exl       <= 1'b0;
                        halted    <= 1'b1;
                        cause     <= EXC_ADEL;
                        bad_vaddr <= pc;
                    end else if (eret && !stall) begin
                        state <= ST_USER;
                        exl   <= 1'b0;
                        pc    <= epc_in;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (br_valid) begin
                        pc <= br_target;
                    end else begin
                        pc <= pc_inc;
                    end
                    // exc_req is not accepted here; the source keeps it asserted
                    // until the handler returns.
                end

                ST_HALT: begin
                    // Only reset leaves HALT.
                    pc <= pc;
                end

                default: begin
                    // Unused encoding: treat as a fatal condition.
                    state  <= ST_HALT;
                    exl    <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_pc_sequencer.sv
module tb_ifu_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        eret;
    logic [31:0] epc_in;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        exl;
    logic [4:0]  cause;
    logic [31:0] epc_out;
    logic [31:0] bad_vaddr;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifu_pc_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .eret        (eret),
        .epc_in      (epc_in),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .exl         (exl),
        .cause       (cause),
        .epc_out     (epc_out),
        .bad_vaddr   (bad_vaddr),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'd0;
        exc_req   = 1'b0;
        exc_code  = 5'd0;
        eret      = 1'b0;
        epc_in    = 32'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},     pc,          32'h0000_3000);
        check({tag, "_exl"},    exl,         32'd0);
        check({tag, "_cause"},  cause,       32'd0);
        check({tag, "_epc"},    epc_out,     32'd0);
        check({tag, "_bad"},    bad_vaddr,   32'd0);
        check({tag, "_halted"}, halted,      32'd0);
        check({tag, "_fv"},     fetch_valid, 32'd1);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        step();
        step();
        check_reset_state("rst");

        // Sequential fetch.
        reset_n = 1'b1;
        check("seq0_pc", pc, 32'h0000_3000);
        check("seq0_fv", fetch_valid, 32'd1);
        step(); check("seq1_pc", pc, 32'h0000_3004);
        step(); check("seq2_pc", pc, 32'h0000_3008);
        step(); check("seq3_pc", pc, 32'h0000_300C);
        check("seq3_fv", fetch_valid, 32'd1);

        // Branch under stall is discarded, then re-presented.
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
        step(); check("stall_pc", pc, 32'h0000_300C);
        stall = 1'b0;
        step(); check("br_pc", pc, 32'h0000_3100);
        br_valid = 1'b0;
        step(); check("br_inc_pc", pc, 32'h0000_3104);

        // Exception round trip from pc 0x3010.
        br_valid = 1'b1; br_target = 32'h0000_3010;
        step(); check("to3010_pc", pc, 32'h0000_3010);
        br_valid = 1'b0; exc_req = 1'b1; exc_code = 5'd8;
        step();
        check("exc_pc",    pc,      32'h0000_4180);
        check("exc_exl",   exl,     32'd1);
        check("exc_epc",   epc_out, 32'h0000_3010);
        check("exc_cause", cause,   32'd8);
        check("exc_fv",    fetch_valid, 32'd1);
        exc_code = 5'd9;
        step();
        check("kexc_pc",    pc,    32'h0000_4184);
        check("kexc_cause", cause, 32'd8);
        check("kexc_epc",   epc_out, 32'h0000_3010);
        check("kexc_exl",   exl,   32'd1);
        exc_req = 1'b0; eret = 1'b1; epc_in = 32'h0000_3014;
        step();
        check("eret_pc",  pc,  32'h0000_3014);
        check("eret_exl", exl, 32'd0);
        // eret in USER is ignored.
        step();
        check("ueret_pc",  pc,  32'h0000_3018);
        check("ueret_exl", exl, 32'd0);
        eret = 1'b0;

        // Exception entry wins over stall; eret waits for stall to drop.
        stall = 1'b1; exc_req = 1'b1; exc_code = 5'd3;
        step();
        check("sexc_pc",    pc,      32'h0000_4180);
        check("sexc_cause", cause,   32'd3);
        check("sexc_epc",   epc_out, 32'h0000_3018);
        exc_req = 1'b0; eret = 1'b1; epc_in = 32'h0000_3020;
        step();
        check("seret_pc",  pc,  32'h0000_4180);
        check("seret_exl", exl, 32'd1);
        stall = 1'b0;
        step();
        check("eret2_pc",  pc,  32'h0000_3020);
        check("eret2_exl", exl, 32'd0);
        eret = 1'b0;

        // Misaligned fetch fault beats a simultaneous exc_req.
        br_valid = 1'b1; br_target = 32'h0000_3102;
        step();
        check("mis_pc", pc, 32'h0000_3102);
        check("mis_fv", fetch_valid, 32'd0);
        br_valid = 1'b0; exc_req = 1'b1; exc_code = 5'd7;
        step();
        check("flt_pc",    pc,        32'h0000_4180);
        check("flt_cause", cause,     32'd4);
        check("flt_bad",   bad_vaddr, 32'h0000_3102);
        check("flt_epc",   epc_out,   32'h0000_3102);
        check("flt_exl",   exl,       32'd1);
        exc_req = 1'b0;

        // Double fault in KERNEL.
        br_valid = 1'b1; br_target = 32'h0000_5000;
        step();
        check("df0_pc", pc, 32'h0000_5000);
        check("df0_fv", fetch_valid, 32'd0);
        check("df0_halted", halted, 32'd0);
        br_valid = 1'b0;
        step();
        check("df_halted", halted,    32'd1);
        check("df_pc",     pc,        32'h0000_5000);
        check("df_bad",    bad_vaddr, 32'h0000_5000);
        check("df_cause",  cause,     32'd4);
        check("df_exl",    exl,       32'd0);
        check("df_fv",     fetch_valid, 32'd0);
        // HALT ignores every request.
        eret = 1'b1; epc_in = 32'h0000_3000; br_valid = 1'b1; br_target = 32'h0000_3000; exc_req = 1'b1;
        step();
        check("halt_pc",     pc,     32'h0000_5000);
        check("halt_halted", halted, 32'd1);
        check("halt_fv",     fetch_valid, 32'd0);
        idle_inputs();

        // One reset edge recovers from HALT.
        reset_n = 1'b0;
        step();
        check_reset_state("rst2");
        reset_n = 1'b1;

        // Upper boundary: 0x4FFC is legal, pc+4 runs past IM_TOP and faults.
        br_valid = 1'b1; br_target = 32'h0000_4FFC;
        step();
        check("top_pc", pc, 32'h0000_4FFC);
        check("top_fv", fetch_valid, 32'd1);
        br_valid = 1'b0;
        step();
        check("over_pc", pc, 32'h0000_5000);
        check("over_fv", fetch_valid, 32'd0);
        step();
        check("over_exc_pc",  pc,        32'h0000_4180);
        check("over_exc_bad", bad_vaddr, 32'h0000_5000);
        // Lower boundary: eret to just below PC_RESET faults in USER.
        eret = 1'b1; epc_in = 32'h0000_2FFC;
        step();
        check("low_pc", pc, 32'h0000_2FFC);
        check("low_fv", fetch_valid, 32'd0);
        eret = 1'b0;
        step();
        check("low_exc_pc",    pc,        32'h0000_4180);
        check("low_exc_bad",   bad_vaddr, 32'h0000_2FFC);
        check("low_exc_cause", cause,     32'd4);
        check("low_exc_halt",  halted,    32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
